// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
// The state encodings are visible on the status LEDs, so they are fixed.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUNNING  = 2'b01,
        ST_PAUSED   = 2'b10,
        ST_LAP_HOLD = 2'b11
    } stopwatch_state_t;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button, debounces it, and emits a one-cycle press
// pulse on each debounced rising edge. Releases produce no event.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= button;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch front panel: two debounced buttons drive the run/pause/lap/clear
// state machine that controls the millisecond timer and the display source.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DEBOUNCE_MS     = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        button_start_stop,
    input  logic        button_lap_reset,
    input  logic [31:0] millisec_counter,
    output logic [7:0]  control_register,
    output logic [31:0] lap_time,
    output logic        lap_valid,
    output logic [31:0] display_value,
    output logic [1:0]  state
);

    localparam int DEBOUNCE_CYCLES = (CLOCK_FREQUENCY / 1000) * DEBOUNCE_MS;

    logic             ss_press, lr_press;
    logic [1:0]       levels_unused;
    stopwatch_state_t state_q, state_d;
    logic             clear_q, clear_d;
    logic [31:0]      lap_q, lap_d;
    logic             lap_valid_q, lap_valid_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clock   (clock),
        .reset_n (reset_n),
        .button  (button_start_stop),
        .level   (levels_unused[0]),
        .press   (ss_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
        .clock   (clock),
        .reset_n (reset_n),
        .button  (button_lap_reset),
        .level   (levels_unused[1]),
        .press   (lr_press)
    );

    // Start/stop is checked first in every state, so it wins over lap/reset.
    always_comb begin
        state_d     = state_q;
        clear_d     = 1'b0;
        lap_d       = lap_q;
        lap_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_press)      state_d = ST_RUNNING;
                else if (lr_press) clear_d = 1'b1;
            end
            ST_RUNNING: begin
                if (ss_press) begin
                    state_d = ST_PAUSED;
                end else if (lr_press) begin
                    state_d     = ST_LAP_HOLD;
                    lap_d       = millisec_counter;
                    lap_valid_d = 1'b1;
                end
            end
            ST_LAP_HOLD: begin
                if (ss_press)      state_d = ST_PAUSED;
                else if (lr_press) state_d = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (ss_press) begin
                    state_d = ST_RUNNING;
                end else if (lr_press) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear is held asserted during reset so the timer starts from zero.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clear_q     <= 1'b1;
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_q     <= clear_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    always_comb begin
        control_register                  = '0;
        control_register[CTRL_ENABLE_BIT] = (state_q == ST_RUNNING) || (state_q == ST_LAP_HOLD);
        control_register[CTRL_CLEAR_BIT]  = clear_q;
    end

    assign lap_time      = lap_q;
    assign lap_valid     = lap_valid_q;
    assign display_value = (state_q == ST_LAP_HOLD) ? lap_q : millisec_counter;
    assign state         = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with DEBOUNCE_CYCLES = 4, so a press
// held from before edge 0 changes state at edge 7 (visible after 8 ticks).
module tb_stopwatch_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        button_start_stop;
    logic        button_lap_reset;
    logic [31:0] millisec_counter;
    logic [7:0]  control_register;
    logic [31:0] lap_time;
    logic        lap_valid;
    logic [31:0] display_value;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    stopwatch_controller #(.CLOCK_FREQUENCY(4000), .DEBOUNCE_MS(1)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .button_start_stop (button_start_stop),
        .button_lap_reset  (button_lap_reset),
        .millisec_counter  (millisec_counter),
        .control_register  (control_register),
        .lap_time          (lap_time),
        .lap_valid         (lap_valid),
        .display_value     (display_value),
        .state             (state)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Full press-and-release with no timing checks, used to move between states.
    task automatic press_ss();
        button_start_stop = 1'b1; tick(10);
        button_start_stop = 1'b0; tick(10);
    endtask

    task automatic press_lr();
        button_lap_reset = 1'b1; tick(10);
        button_lap_reset = 1'b0; tick(10);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++; if (control_register !== 8'h02) begin errors++; $display("FAIL reset_ctrl: got %h expected 02", control_register); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++; if (lap_time !== 32'h0) begin errors++; $display("FAIL reset_lap_time: got %h expected 0", lap_time); end
        checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL reset_lap_valid: got %b expected 0", lap_valid); end
        reset_n = 1'b1;
        tick(1);
        checks++; if (control_register !== 8'h00) begin errors++; $display("FAIL post_reset_ctrl: got %h expected 00", control_register); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL post_reset_state: got %b expected 00", state); end
        tick(5);
    endtask

    task automatic test_start();
        button_start_stop = 1'b1;
        tick(7);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL start_early_state: got %b expected 00", state); end
        tick(1);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state: got %b expected 01", state); end
        checks++; if (control_register !== 8'h01) begin errors++; $display("FAIL start_ctrl: got %h expected 01", control_register); end
        tick(2);
        button_start_stop = 1'b0;
        tick(10);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL release_no_event: got %b expected 01", state); end
        press_ss();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state: got %b expected 10", state); end
        checks++; if (control_register !== 8'h00) begin errors++; $display("FAIL pause_ctrl: got %h expected 00", control_register); end
    endtask

    task automatic test_bounce();
        repeat (5) begin
            button_start_stop = 1'b1; tick(3);
            button_start_stop = 1'b0; tick(1);
        end
        tick(10);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL bounce_reject: got %b expected 10", state); end
        button_start_stop = 1'b1; tick(6);
        button_start_stop = 1'b0; tick(10);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL bounce_single_event: got %b expected 01", state); end
    endtask

    task automatic test_lap();
        millisec_counter = 32'h0000_1234;
        button_lap_reset = 1'b1;
        tick(8);
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL lap_state: got %b expected 11", state); end
        checks++; if (lap_valid !== 1'b1) begin errors++; $display("FAIL lap_valid_pulse: got %b expected 1", lap_valid); end
        checks++; if (lap_time !== 32'h0000_1234) begin errors++; $display("FAIL lap_time: got %h expected 00001234", lap_time); end
        checks++; if (control_register !== 8'h01) begin errors++; $display("FAIL lap_ctrl: got %h expected 01", control_register); end
        tick(1);
        checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL lap_valid_one_cycle: got %b expected 0", lap_valid); end
        tick(1);
        button_lap_reset = 1'b0;
        tick(10);
        millisec_counter = 32'h0000_1300;
        tick(1);
        checks++; if (display_value !== 32'h0000_1234) begin errors++; $display("FAIL lap_display_frozen: got %h expected 00001234", display_value); end
        press_lr();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL lap_resume_state: got %b expected 01", state); end
        checks++; if (display_value !== 32'h0000_1300) begin errors++; $display("FAIL lap_display_live: got %h expected 00001300", display_value); end
        checks++; if (lap_time !== 32'h0000_1234) begin errors++; $display("FAIL lap_time_kept: got %h expected 00001234", lap_time); end
    endtask

    task automatic test_clear();
        press_ss();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL clear_pre_paused: got %b expected 10", state); end
        button_lap_reset = 1'b1;
        tick(7);
        checks++; if (control_register !== 8'h00) begin errors++; $display("FAIL clear_early_ctrl: got %h expected 00", control_register); end
        tick(1);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL clear_state: got %b expected 00", state); end
        checks++; if (control_register !== 8'h02) begin errors++; $display("FAIL clear_pulse: got %h expected 02", control_register); end
        tick(1);
        checks++; if (control_register !== 8'h00) begin errors++; $display("FAIL clear_one_cycle: got %h expected 00", control_register); end
        tick(1);
        button_lap_reset = 1'b0;
        tick(10);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL clear_idle_hold: got %b expected 00", state); end
    endtask

    task automatic test_simultaneous();
        logic saw_lv;
        press_ss();
        saw_lv = 1'b0;
        button_start_stop = 1'b1;
        button_lap_reset  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            saw_lv = saw_lv | lap_valid;
        end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL simul_state: got %b expected 10", state); end
        button_start_stop = 1'b0;
        button_lap_reset  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            saw_lv = saw_lv | lap_valid;
        end
        checks++; if (saw_lv !== 1'b0) begin errors++; $display("FAIL simul_no_lap_valid: got %b expected 0", saw_lv); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL simul_state_hold: got %b expected 10", state); end
    endtask

    task automatic test_wrap();
        press_ss();
        millisec_counter = 32'hFFFF_FFFF;
        button_lap_reset = 1'b1;
        tick(8);
        checks++; if (lap_time !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_lap_time: got %h expected ffffffff", lap_time); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL wrap_state: got %b expected 11", state); end
        checks++; if (display_value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_display: got %h expected ffffffff", display_value); end
        button_lap_reset = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        button_start_stop = 1'b1;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL midreset_state: got %b expected 00", state); end
        checks++; if (control_register !== 8'h02) begin errors++; $display("FAIL midreset_ctrl: got %h expected 02", control_register); end
        checks++; if (lap_time !== 32'h0) begin errors++; $display("FAIL midreset_lap_time: got %h expected 0", lap_time); end
        reset_n = 1'b1;
        tick(7);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_button_early: got %b expected 00", state); end
        tick(1);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL held_button_press: got %b expected 01", state); end
        button_start_stop = 1'b0;
        tick(10);
    endtask

    initial begin
        reset_n           = 1'b0;
        button_start_stop = 1'b0;
        button_lap_reset  = 1'b0;
        millisec_counter  = 32'h0;
        test_reset();
        test_start();
        test_bounce();
        test_lap();
        test_clear();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
